// File: rtl/movegen_pkg.sv
// Shared definitions for the move-generation sequencer: piece codes, generator
// register indices, board geometry and scheduler state encodings.
package movegen_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_e;

    localparam logic [2:0] GREG_START = 3'd0;
    localparam logic [2:0] GREG_SRC   = 3'd1;
    localparam logic [2:0] GREG_DEST  = 3'd2;
    localparam logic [2:0] GREG_X     = 3'd3;
    localparam logic [2:0] GREG_Y     = 3'd4;

    localparam logic [31:0] BOARD_BYTES = 32'd256;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD_SQ  = 4'd1;
    localparam logic [3:0] S_WT_SQ  = 4'd2;
    localparam logic [3:0] S_DECIDE = 4'd3;
    localparam logic [3:0] S_GEN_WR = 4'd4;
    localparam logic [3:0] S_GEN_RD = 4'd5;
    localparam logic [3:0] S_ACCUM  = 4'd6;
    localparam logic [3:0] S_NEXT   = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    // Magnitude of a signed 8-bit piece code; -128 maps to 128 so it reads as invalid.
    function automatic logic [7:0] piece_mag(input logic [7:0] pc);
        return pc[7] ? (~pc + 8'd1) : pc;
    endfunction

endpackage

// File: rtl/movegen_sched.sv
// Scans a 64-square board in SDRAM and dispatches each own-colour piece to its
// generator, packing generated boards contiguously into the destination buffer.
module movegen_sched
    import movegen_pkg::*;
#(
    parameter logic [31:0] GEN_BASE      = 32'h0000_1000,
    parameter logic [31:0] GEN_STRIDE    = 32'h0000_0040,
    parameter logic [31:0] MAX_PER_PIECE = 32'd27
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        mem_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    input  logic        gen_waitrequest,
    output logic [31:0] gen_address,
    output logic        gen_read,
    input  logic [31:0] gen_readdata,
    output logic        gen_write,
    output logic [31:0] gen_writedata
);

    logic [3:0]  state_reg;
    logic [5:0]  sq_reg;
    logic [7:0]  pc_reg;
    logic [2:0]  widx_reg;
    logic [31:0] win_reg;
    logic [7:0]  count_reg;
    logic [31:0] src_reg;
    logic [31:0] dest_reg;
    logic        side_reg;
    logic [31:0] cap_reg;
    logic [31:0] total_reg;
    logic [31:0] disp_reg;
    logic [31:0] dest_ptr_reg;
    logic        done_reg;
    logic        ovf_reg;
    logic        bad_reg;

    logic [7:0]  pc_mag;
    logic [2:0]  gen_idx;
    logic        wrong_side;
    logic        bad_piece;
    logic        no_room;
    logic        start_cmd;
    logic        unused_bits;

    assign slave_waitrequest = 1'b0;
    assign unused_bits = ^{slave_read, mem_readdata[31:8], gen_readdata[31:8]};

    assign start_cmd = slave_write && (slave_address == 4'd0) && (state_reg == S_IDLE);

    always_comb begin
        pc_mag     = piece_mag(pc_reg);
        gen_idx    = pc_mag[2:0] - 3'd1;
        wrong_side = (pc_reg == 8'd0) || (pc_reg[7] != side_reg);
        bad_piece  = (pc_mag > {5'd0, KING}) || (pc_reg == 8'h80);
        no_room    = ({1'b0, total_reg} + {1'b0, MAX_PER_PIECE}) > {1'b0, cap_reg};
    end

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            4'd0: slave_readdata = {29'd0, bad_reg, ovf_reg, done_reg};
            4'd1: slave_readdata = src_reg;
            4'd2: slave_readdata = dest_reg;
            4'd3: slave_readdata = {31'd0, side_reg};
            4'd4: slave_readdata = cap_reg;
            4'd5: slave_readdata = total_reg;
            4'd6: slave_readdata = disp_reg;
            default: slave_readdata = '0;
        endcase
    end

    // Bus strobes and addresses depend only on state, so reset silences them at once.
    assign mem_read  = (state_reg == S_RD_SQ);
    assign gen_write = (state_reg == S_GEN_WR);
    assign gen_read  = (state_reg == S_GEN_RD);

    assign mem_address = mem_read ? (src_reg + {24'd0, sq_reg, 2'b00}) : 32'hFFFF_FFFF;

    always_comb begin
        gen_address   = 32'hFFFF_FFFF;
        gen_writedata = '0;
        if (gen_write) begin
            gen_address = win_reg + {27'd0, widx_reg, 2'b00};
            case (widx_reg)
                GREG_SRC:  gen_writedata = src_reg;
                GREG_DEST: gen_writedata = dest_ptr_reg;
                GREG_X:    gen_writedata = {29'd0, sq_reg[2:0]};
                GREG_Y:    gen_writedata = {29'd0, sq_reg[5:3]};
                default:   gen_writedata = 32'd1;
            endcase
        end else if (gen_read) begin
            gen_address = win_reg + {27'd0, GREG_START, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            sq_reg       <= '0;
            pc_reg       <= '0;
            widx_reg     <= '0;
            win_reg      <= '0;
            count_reg    <= '0;
            src_reg      <= '0;
            dest_reg     <= '0;
            side_reg     <= 1'b0;
            cap_reg      <= '0;
            total_reg    <= '0;
            disp_reg     <= '0;
            dest_ptr_reg <= '0;
            done_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            bad_reg      <= 1'b0;
        end else begin
            if (slave_write && (state_reg == S_IDLE)) begin
                case (slave_address)
                    4'd1: src_reg  <= slave_writedata;
                    4'd2: dest_reg <= slave_writedata;
                    4'd3: side_reg <= slave_writedata[0];
                    4'd4: cap_reg  <= slave_writedata;
                    default: ;
                endcase
            end

            case (state_reg)
                S_IDLE: begin
                    if (start_cmd) begin
                        done_reg     <= 1'b0;
                        ovf_reg      <= 1'b0;
                        bad_reg      <= 1'b0;
                        total_reg    <= '0;
                        disp_reg     <= '0;
                        sq_reg       <= '0;
                        dest_ptr_reg <= dest_reg;
                        state_reg    <= S_RD_SQ;
                    end
                end
                S_RD_SQ: begin
                    if (!mem_waitrequest) state_reg <= S_WT_SQ;
                end
                S_WT_SQ: begin
                    if (mem_readdatavalid) begin
                        pc_reg    <= mem_readdata[7:0];
                        state_reg <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (wrong_side) begin
                        state_reg <= S_NEXT;
                    end else if (bad_piece) begin
                        bad_reg   <= 1'b1;
                        state_reg <= S_NEXT;
                    end else if (no_room) begin
                        ovf_reg   <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        win_reg   <= GEN_BASE + ({29'd0, gen_idx} * GEN_STRIDE);
                        widx_reg  <= GREG_SRC;
                        state_reg <= S_GEN_WR;
                    end
                end
                S_GEN_WR: begin
                    // Argument registers 1..4 first, then the start register 0.
                    if (!gen_waitrequest) begin
                        if (widx_reg == GREG_START) begin
                            state_reg <= S_GEN_RD;
                        end else if (widx_reg == GREG_Y) begin
                            widx_reg <= GREG_START;
                        end else begin
                            widx_reg <= widx_reg + 3'd1;
                        end
                    end
                end
                S_GEN_RD: begin
                    if (!gen_waitrequest) begin
                        count_reg <= gen_readdata[7:0];
                        state_reg <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    total_reg    <= total_reg + {24'd0, count_reg};
                    dest_ptr_reg <= dest_ptr_reg + ({24'd0, count_reg} * BOARD_BYTES);
                    disp_reg     <= disp_reg + 32'd1;
                    state_reg    <= S_NEXT;
                end
                S_NEXT: begin
                    if (sq_reg == 6'd63) begin
                        state_reg <= S_DONE;
                    end else begin
                        sq_reg    <= sq_reg + 6'd1;
                        state_reg <= S_RD_SQ;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_movegen_sched.sv
// Self-checking bench for movegen_sched: SDRAM and generator models, a queue of
// expected generator writes, and a table of whole-board scan scenarios.
module tb_movegen_sched;

    localparam logic [31:0] GB  = 32'h0000_1000;
    localparam logic [31:0] GS  = 32'h0000_0040;
    localparam logic [31:0] SRC = 32'h0000_8000;
    localparam logic [31:0] DST = 32'h0010_0000;

    logic        clk;
    logic        rst_n;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        gen_waitrequest;
    logic [31:0] gen_address;
    logic        gen_read;
    logic [31:0] gen_readdata;
    logic        gen_write;
    logic [31:0] gen_writedata;

    movegen_sched #(
        .GEN_BASE(GB),
        .GEN_STRIDE(GS),
        .MAX_PER_PIECE(32'd27)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .slave_waitrequest(slave_waitrequest),
        .slave_address(slave_address),
        .slave_read(slave_read),
        .slave_readdata(slave_readdata),
        .slave_write(slave_write),
        .slave_writedata(slave_writedata),
        .mem_waitrequest(mem_waitrequest),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .gen_waitrequest(gen_waitrequest),
        .gen_address(gen_address),
        .gen_read(gen_read),
        .gen_readdata(gen_readdata),
        .gen_write(gen_write),
        .gen_writedata(gen_writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int mem_reads = 0;
    int viol = 0;

    logic [31:0] board [64];
    logic [7:0]  ret_by_sq [64];
    logic [2:0]  gx = 3'd0;
    logic [2:0]  gy = 3'd0;
    logic [31:0] mem_off;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_data;
    } gtx_t;
    gtx_t exp_q[$];

    typedef struct {
        logic         side;
        logic [31:0]  cap;
        logic [2:0][7:0] sq;
        logic [2:0][7:0] pc;
        logic [2:0][7:0] ret;
        logic [2:0]   disp;
        logic [31:0]  e_total;
        logic [31:0]  e_disp;
        logic [31:0]  e_reads;
        logic         e_ovf;
        logic         e_bad;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // SDRAM: one-cycle read latency after an accepted read.
    assign mem_off = mem_address - SRC;
    always @(posedge clk) begin
        mem_readdatavalid <= 1'b0;
        if (mem_read && !mem_waitrequest) begin
            mem_readdatavalid <= 1'b1;
            mem_readdata      <= board[mem_off[7:2]];
            mem_reads         <= mem_reads + 1;
        end
        if (gen_write && !gen_waitrequest) begin
            if (gen_address[4:2] == 3'd3) gx <= gen_writedata[2:0];
            if (gen_address[4:2] == 3'd4) gy <= gen_writedata[2:0];
        end
    end

    // Generator returns a per-square count chosen by the test; upper bits are junk.
    assign gen_readdata = {24'h777777, ret_by_sq[{gy, gx}]};

    initial begin
        mem_waitrequest = 1'b0;
        gen_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_waitrequest = ($urandom_range(0, 3) == 0);
            gen_waitrequest = gen_read ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
        end
    end

    // Generator-side scoreboard: each accepted write pops one expectation.
    initial begin
        gtx_t t;
        forever begin
            @(negedge clk);
            if ((32'(mem_read) + 32'(gen_read) + 32'(gen_write)) > 1) viol++;
            if (gen_write && !gen_waitrequest) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL gen_unexpected: got write %h at %h expected none", gen_writedata, gen_address);
                end else begin
                    t = exp_q.pop_front();
                    check("gen_wr_addr", gen_address, t.addr);
                    if (t.chk_data) check("gen_wr_data", gen_writedata, t.data);
                end
            end
        end
    end

    task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        #1;
        d = slave_readdata;
        slave_read    = 1'b0;
    endtask

    function automatic vec_t mk(input logic side, input logic [31:0] cap,
                                input logic [23:0] sq, input logic [23:0] pc,
                                input logic [23:0] ret, input logic [2:0] disp,
                                input logic [31:0] et, input logic [31:0] ed,
                                input logic [31:0] er, input logic eo, input logic eb);
        vec_t v;
        v.side = side; v.cap = cap; v.sq = sq; v.pc = pc; v.ret = ret; v.disp = disp;
        v.e_total = et; v.e_disp = ed; v.e_reads = er; v.e_ovf = eo; v.e_bad = eb;
        return v;
    endfunction

    // Loads the board, queues the expected generator traffic and programs the block.
    task automatic setup_vec(input vec_t v);
        logic [31:0] dp;
        logic [31:0] win;
        int m;
        for (int i = 0; i < 64; i++) begin
            board[i]     = {24'hA5A5A5, 8'h00};
            ret_by_sq[i] = 8'hEE;
        end
        dp = DST;
        for (int k = 0; k < 3; k++) begin
            if (v.pc[k] != 8'd0) begin
                board[v.sq[k][5:0]]     = {24'hA5A5A5, v.pc[k]};
                ret_by_sq[v.sq[k][5:0]] = v.ret[k];
            end
            if (v.disp[k]) begin
                m   = $signed(v.pc[k]) < 0 ? -int'($signed(v.pc[k])) : int'($signed(v.pc[k]));
                win = GB + 32'(m - 1) * GS;
                exp_q.push_back('{win + 32'd4,  SRC, 1'b1});
                exp_q.push_back('{win + 32'd8,  dp,  1'b1});
                exp_q.push_back('{win + 32'd12, 32'(v.sq[k] % 8), 1'b1});
                exp_q.push_back('{win + 32'd16, 32'(v.sq[k] / 8), 1'b1});
                exp_q.push_back('{win,          32'd0, 1'b0});
                dp = dp + 32'(v.ret[k]) * 32'd256;
            end
        end
        cpu_wr(4'd1, SRC);
        cpu_wr(4'd2, DST);
        cpu_wr(4'd3, {31'd0, v.side});
        cpu_wr(4'd4, v.cap);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit poke);
        logic [31:0] rd;
        int r0;
        bit fin;
        setup_vec(v);
        r0 = mem_reads;
        cpu_wr(4'd0, 32'd0);
        if (poke) begin
            cpu_wr(4'd1, 32'hDEAD_0000);
            cpu_wr(4'd0, 32'd0);
        end
        fin = 1'b0;
        rd  = '0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            cpu_rd(4'd0, rd);
            fin = rd[0];
        end
        check({tag, "_done"}, {31'd0, fin}, 32'd1);
        check({tag, "_ovf"}, {31'd0, rd[1]}, {31'd0, v.e_ovf});
        check({tag, "_bad"}, {31'd0, rd[2]}, {31'd0, v.e_bad});
        cpu_rd(4'd5, rd);
        check({tag, "_total"}, rd, v.e_total);
        cpu_rd(4'd6, rd);
        check({tag, "_dispatched"}, rd, v.e_disp);
        check({tag, "_mem_reads"}, 32'(mem_reads - r0), v.e_reads);
        check({tag, "_gen_left"}, 32'(exp_q.size()), 32'd0);
        if (poke) begin
            cpu_rd(4'd1, rd);
            check({tag, "_src_kept"}, rd, SRC);
        end
        $display("%s: total=%0d dispatched=%0d", tag, v.e_total, v.e_disp);
        exp_q.delete();
    endtask

    vec_t vt [7];

    initial begin
        logic [31:0] rd;
        bit seen;

        vt[0] = mk(1'b0, 32'd1000, {8'd0, 8'd0, 8'd0},  {8'd0, 8'd0, 8'd0},    {8'd0, 8'd0, 8'd0}, 3'b000, 32'd0, 32'd0, 32'd64, 1'b0, 1'b0);
        vt[1] = mk(1'b0, 32'd1000, {8'd0, 8'd0, 8'd1},  {8'd0, 8'd0, 8'd2},    {8'd0, 8'd0, 8'd3}, 3'b001, 32'd3, 32'd1, 32'd64, 1'b0, 1'b0);
        vt[2] = mk(1'b0, 32'd1000, {8'd0, 8'd4, 8'd0},  {8'd0, 8'd6, 8'd4},    {8'd0, 8'd5, 8'd2}, 3'b011, 32'd7, 32'd2, 32'd64, 1'b0, 1'b0);
        vt[3] = mk(1'b1, 32'd1000, {8'd0, 8'd8, 8'd3},  {8'd0, 8'd1, 8'd5},    {8'd0, 8'd1, 8'd1}, 3'b000, 32'd0, 32'd0, 32'd64, 1'b0, 1'b0);
        vt[4] = mk(1'b0, 32'd30,   {8'd0, 8'd20, 8'd2}, {8'd0, 8'd4, 8'd5},    {8'd0, 8'd4, 8'd5}, 3'b001, 32'd5, 32'd1, 32'd21, 1'b1, 1'b0);
        vt[5] = mk(1'b0, 32'd1000, {8'd0, 8'd12, 8'd10},{8'd0, 8'd1, 8'd9},    {8'd0, 8'd1, 8'd0}, 3'b010, 32'd1, 32'd1, 32'd64, 1'b0, 1'b1);
        vt[6] = mk(1'b1, 32'd1000, {8'd60, 8'd50, 8'd5},{8'h80, 8'hFE, 8'd9},  {8'd0, 8'd2, 8'd0}, 3'b010, 32'd2, 32'd1, 32'd64, 1'b0, 1'b1);

        rst_n           = 1'b0;
        slave_address   = 4'd0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = '0;
        for (int i = 0; i < 64; i++) begin
            board[i]     = '0;
            ret_by_sq[i] = '0;
        end

        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_gen_read", {31'd0, gen_read}, 32'd0);
        check("rst_gen_write", {31'd0, gen_write}, 32'd0);
        check("rst_mem_address", mem_address, 32'hFFFF_FFFF);
        check("rst_gen_address", gen_address, 32'hFFFF_FFFF);
        check("rst_status", slave_readdata, 32'd0);
        check("rst_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_rd(4'd5, rd);
        check("rst_total", rd, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i), 1'b0);

        run_vec(vt[1], "busy_writes", 1'b1);

        // Reset while the generator count read is outstanding.
        setup_vec(vt[1]);
        cpu_wr(4'd0, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            seen = gen_read;
        end
        check("midrst_reached_gen_rd", {31'd0, seen}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_gen_read", {31'd0, gen_read}, 32'd0);
        check("midrst_gen_write", {31'd0, gen_write}, 32'd0);
        check("midrst_mem_read", {31'd0, mem_read}, 32'd0);
        check("midrst_gen_address", gen_address, 32'hFFFF_FFFF);
        check("midrst_gen_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cpu_rd(4'd0, rd);
        check("midrst_status", rd, 32'd0);
        cpu_rd(4'd6, rd);
        check("midrst_dispatched", rd, 32'd0);
        $display("midrst: reset taken during generator read");

        check("strobe_exclusive", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
